// File: rtl/uart_fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter for the write port of the UART TX FIFO.
// Each grant covers a whole packet (up to MAX_BURST beats) so frames from
// different producers never interleave. FIFO clears are deferred to a burst
// boundary and issued as a single-cycle pulse.
module uart_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               fifo_wr,
    output logic [DATA_WIDTH-1:0]              fifo_data,
    input  logic                               fifo_full,
    input  logic [FIFO_DEPTH:0]                fifo_use_words,
    input  logic                               clear_req,
    output logic                               fifo_clear,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               clr_pend_q, clr_pend_d;

    // Per-requester data split out of the flat bus
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    // Round-robin search results
    logic [ID_W:0]      cand;
    logic [ID_W-1:0]    win_id;
    logic               win_found;

    // Selected-requester view during a burst
    logic               xfer_active;
    logic               sel_valid;
    logic               sel_last;
    logic               beat_accept;
    logic               burst_end;
    logic [ID_W-1:0]    rr_after_grant;

    // fifo_use_words is informational only; the full flag alone gates writes.

    assign xfer_active = (state_q == ST_XFER);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            // Only the granted requester sees ready, and only while the FIFO has room
            assign req_ready[gi]    = xfer_active && (grant_q == ID_W'(gi)) && !fifo_full;
        end
    endgenerate

    assign sel_valid      = req_valid[grant_q];
    assign sel_last       = req_last[grant_q];
    assign beat_accept    = xfer_active && sel_valid && !fifo_full;
    assign burst_end      = beat_accept &&
                            (sel_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
    assign rr_after_grant = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    assign fifo_data = req_data_arr[grant_q];
    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);

    // Pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    // Next-state and output decode for the IDLE/XFER/CLEAR sequencer
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        clr_pend_d = clr_pend_q;
        fifo_wr    = 1'b0;
        fifo_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending or fresh flush takes priority over a new grant
                if (clr_pend_q || clear_req) begin
                    state_d = ST_CLEAR;
                end else if (win_found) begin
                    grant_d    = win_id;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end

            ST_XFER: begin
                fifo_wr    = beat_accept;
                // Flush requests are remembered until the packet completes
                clr_pend_d = clr_pend_q || clear_req;
                if (beat_accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (burst_end) begin
                    rr_ptr_d = rr_after_grant;
                    state_d  = (clr_pend_q || clear_req) ? ST_CLEAR : ST_IDLE;
                end
            end

            ST_CLEAR: begin
                // A clear_req arriving now is covered by this pulse
                fifo_clear = 1'b1;
                clr_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            clr_pend_q <= clr_pend_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_wr_arbiter.sv
// Scoreboard bench for uart_fifo_wr_arbiter: directed packets feed behavioural
// producers, expected FIFO writes/clears are queued up front and a negedge
// monitor pops and compares them as the DUT emits them.
module tb_uart_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_BURST  = 16;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_full;
    logic [FIFO_DEPTH:0]           fifo_use_words;
    logic                          clear_req;
    logic                          fifo_clear;
    logic [1:0]                    grant_id;
    logic                          busy;

    always #5 clk = ~clk;

    uart_fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_wr       (fifo_wr),
        .fifo_data     (fifo_data),
        .fifo_full     (fifo_full),
        .fifo_use_words(fifo_use_words),
        .clear_req     (clear_req),
        .fifo_clear    (fifo_clear),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    typedef struct packed {
        logic       is_clr;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Producer packet storage: bit 8 = last flag, bits 7:0 = data
    logic [8:0] mem [NUM_REQ][64];
    int         head [NUM_REQ];
    int         tail [NUM_REQ];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_pkt(input int id, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            mem[id][tail[id]] = {(k == n - 1), base + 8'(k)};
            tail[id]++;
        end
    endtask

    task automatic exp_w(input logic [1:0] id, input logic [7:0] data);
        exp_q.push_back({1'b0, id, data});
    endtask

    task automatic exp_c();
        exp_q.push_back({1'b1, 2'd0, 8'd0});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300) begin
            cyc();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // Behavioural producers: present queue heads, pop on a seen handshake
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && head[i] != tail[i]) head[i]++;
                if (head[i] != tail[i]) begin
                    req_valid[i]               = 1'b1;
                    req_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][head[i]][7:0];
                    req_last[i]                = mem[i][head[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: every FIFO write/clear must match the next expected event
    always @(negedge clk) begin
        exp_t e;
        if (fifo_wr === 1'b1 || fifo_clear === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: wr=%0b clr=%0b id=%0d data=%02h with nothing expected",
                         fifo_wr, fifo_clear, grant_id, fifo_data);
            end else begin
                e = exp_q.pop_front();
                if (e.is_clr) begin
                    if (!(fifo_clear === 1'b1 && fifo_wr === 1'b0)) begin
                        failures++;
                        $display("FAIL sb_clear: got wr=%0b clr=%0b expected clear pulse", fifo_wr, fifo_clear);
                    end
                    $display("sb clear ok=%0b", fifo_clear === 1'b1 && fifo_wr === 1'b0);
                end else begin
                    if (!(fifo_wr === 1'b1 && fifo_clear === 1'b0 &&
                          fifo_data === e.data && grant_id === e.id)) begin
                        failures++;
                        $display("FAIL sb_write: got wr=%0b clr=%0b id=%0d data=%02h expected id=%0d data=%02h",
                                 fifo_wr, fifo_clear, grant_id, fifo_data, e.id, e.data);
                    end else begin
                        $display("sb write id=%0d data=%02h", grant_id, fifo_data);
                    end
                end
            end
        end
        if (fifo_full === 1'b1 || fifo_clear === 1'b1) begin
            checks++;
            if (fifo_wr !== 1'b0) begin
                failures++;
                $display("FAIL wr_guard: got fifo_wr=%0b expected 0 (full=%0b clr=%0b)",
                         fifo_wr, fifo_full, fifo_clear);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        clear_req      = 1'b0;
        fifo_full      = 1'b0;
        fifo_use_words = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr", fifo_wr, 0);
        chk("rst_clear", fifo_clear, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        cyc();
        reset = 1'b0;
        cyc();

        // Round-robin order 0,1,2,3,0 with one idle cycle between writes
        push_pkt(0, 8'h10, 1);
        push_pkt(1, 8'h11, 1);
        push_pkt(2, 8'h12, 1);
        push_pkt(3, 8'h13, 1);
        push_pkt(0, 8'h14, 1);
        exp_w(0, 8'h10); exp_w(1, 8'h11); exp_w(2, 8'h12); exp_w(3, 8'h13); exp_w(0, 8'h14);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_wr_slot", fifo_wr, k % 2);
            cyc();
        end
        wait_done();

        // 3-beat packet from req0, one cycle latency, busy drops after
        push_pkt(0, 8'hA1, 3);
        exp_w(0, 8'hA1); exp_w(0, 8'hA2); exp_w(0, 8'hA3);
        @(negedge clk);
        chk("t1_lat0", fifo_wr, 0);
        cyc();
        @(negedge clk);
        chk("t1_first_wr", fifo_wr, 1);
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_busy", busy, 1);
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("t1_busy_fall", busy, 0);
        chk("t1_wr_end", fifo_wr, 0);
        cyc();
        wait_done();

        // 20-beat packet split at MAX_BURST, req2 interleaves at the boundary
        push_pkt(1, 8'h30, 20);
        push_pkt(2, 8'hC0, 2);
        for (int k = 0; k < 16; k++) exp_w(1, 8'h30 + 8'(k));
        exp_w(2, 8'hC0); exp_w(2, 8'hC1);
        for (int k = 16; k < 20; k++) exp_w(1, 8'h30 + 8'(k));
        wait_done();

        // FIFO full for 5 cycles mid-burst on req3
        push_pkt(3, 8'h50, 4);
        for (int k = 0; k < 4; k++) exp_w(3, 8'h50 + 8'(k));
        cyc(); cyc();
        @(negedge clk);
        chk("t4_ready_pre", req_ready, 4'b1000);
        cyc();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_stall_ready", req_ready, 0);
            chk("t4_stall_wr", fifo_wr, 0);
            chk("t4_stall_grant", grant_id, 3);
            cyc();
        end
        fifo_full = 1'b0;
        wait_done();

        // Clear request mid-burst is deferred until after the last beat
        push_pkt(0, 8'h60, 4);
        for (int k = 0; k < 4; k++) exp_w(0, 8'h60 + 8'(k));
        exp_c();
        cyc();
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        cyc();
        @(negedge clk);
        chk("t5_last_beat_no_clear", fifo_clear, 0);
        cyc();
        @(negedge clk);
        chk("t5_clear_pulse", fifo_clear, 1);
        chk("t5_clear_busy", busy, 1);
        cyc();
        @(negedge clk);
        chk("t5_clear_once", fifo_clear, 0);
        chk("t5_idle", busy, 0);
        cyc();
        wait_done();

        // Reset during beat 3 of a req2 burst; afterwards req0 beats req3
        push_pkt(2, 8'h70, 5);
        exp_w(2, 8'h70); exp_w(2, 8'h71); exp_w(2, 8'h72);
        cyc(); cyc(); cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_beat3_wr", fifo_wr, 1);
        cyc();
        reset   = 1'b0;
        head[2] = tail[2];
        push_pkt(0, 8'h80, 1);
        push_pkt(3, 8'h90, 1);
        exp_w(0, 8'h80); exp_w(3, 8'h90);
        @(negedge clk);
        chk("t6_ready", req_ready, 0);
        chk("t6_wr", fifo_wr, 0);
        chk("t6_grant", grant_id, 0);
        chk("t6_busy", busy, 0);
        cyc();
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
